// File: rtl/rpn_bcd_stack_if.sv
// Keypad-side bus of the RPN BCD calculator core: key input plus display/status outputs.
// Ports: key_code/key_valid (keypad -> core); view_bcd, view_idx, sp, view_not_top,
// busy, error (core -> display). Master = keypad/display side, slave = calculator core.
interface rpn_bcd_stack_if #(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
);
    logic [4:0]          key_code;
    logic                key_valid;
    logic [4*DIGITS-1:0] view_bcd;
    logic [PTR_W-1:0]    view_idx;
    logic [PTR_W-1:0]    sp;
    logic                view_not_top;
    logic                busy;
    logic                error;

    modport master (
        output key_code, key_valid,
        input  view_bcd, view_idx, sp, view_not_top, busy, error
    );

    modport slave (
        input  key_code, key_valid,
        output view_bcd, view_idx, sp, view_not_top, busy, error
    );
endinterface

// File: rtl/rpn_bcd_stack.sv
// RPN calculator core: DEPTH-entry stack of DIGITS-digit packed-BCD numbers (DIGITS >= 2),
// keyed by 5-bit codes; add/subtract run one BCD digit per clock through a single digit adder.
// Latency: single-cycle keys 1 clock after the key edge, PLUS/MINUS DIGITS+2 clocks; view
// outputs one clock later. Backpressure: key edges arriving while busy are dropped.
// Ports: clk, rst (async active-high), bus (rpn_bcd_stack_if.slave).
// Optional feature: define RPN_SWAP_EN to implement SWAP (10111); otherwise it is a NOP.
module rpn_bcd_stack #(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    rpn_bcd_stack_if.slave bus
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS) + 1;

    localparam logic [4:0] K_PLUS  = 5'b10000;
    localparam logic [4:0] K_MINUS = 5'b10001;
    localparam logic [4:0] K_BACKS = 5'b10010;
    localparam logic [4:0] K_ENTER = 5'b10011;
    localparam logic [4:0] K_UP    = 5'b10100;
    localparam logic [4:0] K_DOWN  = 5'b10101;
`ifdef RPN_SWAP_EN
    localparam logic [4:0] K_SWAP  = 5'b10111;
`endif
    localparam logic [4:0] K_CLEAR = 5'b11000;

    typedef enum logic [1:0] {IDLE, EXEC, ARITH, WRITE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       key_q, key_d;
    logic             key_prev_q, key_prev_d;
    logic [W-1:0]     stack_q [DEPTH];
    logic [W-1:0]     stack_d [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W-1:0] view_idx_q, view_idx_d;
    logic             error_q, error_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [PTR_W-1:0] dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     view_bcd_q, view_bcd_d;
    logic             view_not_top_q, view_not_top_d;

    logic [W-1:0] top;
    logic         key_event;
    logic         follow_sp;
    logic [4:0]   sum5, diff5;
    logic [3:0]   dig;
    logic         cout;

    assign top       = stack_q[sp_q];
    // Previous sample resets high so a key held through reset release is not an event.
    assign key_event = bus.key_valid & ~key_prev_q;

    // One decimal digit of A op B, least significant digit sits in bits [3:0].
    assign sum5  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    assign diff5 = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, carry_q};

    always_comb begin
        dig  = 4'd0;
        cout = 1'b0;
        if (sub_q) begin
            // Negative difference wraps in 5 bits; adding 10 to the low nibble gives the digit.
            dig  = diff5[4] ? diff5[3:0] + 4'd10 : diff5[3:0];
            cout = diff5[4];
        end else begin
            dig  = (sum5 > 5'd9) ? sum5[3:0] + 4'd6 : sum5[3:0];
            cout = (sum5 > 5'd9);
        end
    end

    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        key_prev_d     = bus.key_valid;
        stack_d        = stack_q;
        sp_d           = sp_q;
        view_idx_d     = view_idx_q;
        error_d        = error_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        carry_d        = carry_q;
        sub_d          = sub_q;
        dest_d         = dest_q;
        cnt_d          = cnt_q;
        view_bcd_d     = stack_q[view_idx_q];
        view_not_top_d = (view_idx_q != sp_q);
        follow_sp      = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_event) begin
                    key_d   = bus.key_code;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (key_q == K_CLEAR) begin
                    for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
                    sp_d      = '0;
                    error_d   = 1'b0;
                    follow_sp = 1'b1;
                end else if (error_q) begin
                    // First key after an error only acknowledges it.
                    error_d = 1'b0;
                end else if (!key_q[4]) begin
                    if (key_q[3:0] <= 4'd9) begin
                        if (top[W-1 -: 4] == 4'd0) stack_d[sp_q] = {top[W-5:0], key_q[3:0]};
                        follow_sp = 1'b1;
                    end
                end else begin
                    case (key_q)
                        K_ENTER: begin
                            if (top != '0) begin
                                if (sp_q != PTR_W'(DEPTH - 1)) begin
                                    sp_d          = sp_q + PTR_W'(1);
                                    stack_d[sp_d] = '0;
                                end else begin
                                    error_d = 1'b1;
                                end
                            end
                            follow_sp = 1'b1;
                        end
                        K_PLUS, K_MINUS: begin
                            sub_d   = (key_q == K_MINUS);
                            carry_d = 1'b0;
                            cnt_d   = '0;
                            if (top != '0 && sp_q != '0) begin
                                a_d     = stack_q[sp_q - PTR_W'(1)];
                                b_d     = top;
                                dest_d  = sp_q - PTR_W'(1);
                                state_d = ARITH;
                            end else if (top == '0 && sp_q >= PTR_W'(2)) begin
                                // Empty edit entry: operate on the two entries below it.
                                a_d     = stack_q[sp_q - PTR_W'(2)];
                                b_d     = stack_q[sp_q - PTR_W'(1)];
                                dest_d  = sp_q - PTR_W'(2);
                                state_d = ARITH;
                            end else begin
                                if (top == '0 && sp_q == PTR_W'(1)) sp_d = '0;
                                follow_sp = 1'b1;
                            end
                        end
                        K_BACKS: begin
                            if (top != '0) stack_d[sp_q] = {4'd0, top[W-1:4]};
                            else if (sp_q != '0) sp_d = sp_q - PTR_W'(1);
                            follow_sp = 1'b1;
                        end
                        K_UP: begin
                            if (view_idx_q != '0) view_idx_d = view_idx_q - PTR_W'(1);
                        end
                        K_DOWN: begin
                            if (view_idx_q < sp_q) view_idx_d = view_idx_q + PTR_W'(1);
                        end
`ifdef RPN_SWAP_EN
                        K_SWAP: begin
                            if (sp_q != '0) begin
                                stack_d[sp_q]             = stack_q[sp_q - PTR_W'(1)];
                                stack_d[sp_q - PTR_W'(1)] = top;
                            end
                            follow_sp = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ARITH: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = {dig, res_q[W-1:4]};
                carry_d = cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIGITS - 1)) state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                if (carry_q) begin
                    error_d = 1'b1;
                end else begin
                    stack_d[dest_q] = res_q;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (PTR_W'(i) > dest_q) stack_d[i] = '0;
                    end
                    sp_d = dest_q;
                end
                follow_sp = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (follow_sp) view_idx_d = sp_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            key_q          <= '0;
            key_prev_q     <= 1'b1;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            sp_q           <= '0;
            view_idx_q     <= '0;
            error_q        <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            carry_q        <= 1'b0;
            sub_q          <= 1'b0;
            dest_q         <= '0;
            cnt_q          <= '0;
            view_bcd_q     <= '0;
            view_not_top_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            key_prev_q     <= key_prev_d;
            stack_q        <= stack_d;
            sp_q           <= sp_d;
            view_idx_q     <= view_idx_d;
            error_q        <= error_d;
            a_q            <= a_d;
            b_q            <= b_d;
            res_q          <= res_d;
            carry_q        <= carry_d;
            sub_q          <= sub_d;
            dest_q         <= dest_d;
            cnt_q          <= cnt_d;
            view_bcd_q     <= view_bcd_d;
            view_not_top_q <= view_not_top_d;
        end
    end

    assign bus.view_bcd     = view_bcd_q;
    assign bus.view_idx     = view_idx_q;
    assign bus.sp           = sp_q;
    assign bus.view_not_top = view_not_top_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.error        = error_q;
endmodule

// File: tb/tb_rpn_bcd_stack.sv
// Bench for rpn_bcd_stack (DIGITS=4, DEPTH=16): directed key sequences with hand-computed
// expected display state pushed into a queue; a monitor pops one entry per busy pulse and
// compares once the registered view has settled. Honours RPN_SWAP_EN for the SWAP case.
module tb_rpn_bcd_stack;
    localparam logic [4:0] K_PLUS  = 5'b10000;
    localparam logic [4:0] K_MINUS = 5'b10001;
    localparam logic [4:0] K_BACKS = 5'b10010;
    localparam logic [4:0] K_ENTER = 5'b10011;
    localparam logic [4:0] K_UP    = 5'b10100;
    localparam logic [4:0] K_DOWN  = 5'b10101;
    localparam logic [4:0] K_SWAP  = 5'b10111;
    localparam logic [4:0] K_CLEAR = 5'b11000;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  sp;
        logic [3:0]  vidx;
        logic        vnt;
        logic        err;
        logic [3:0]  blen;   // expected busy length in cycles, 0 = not checked
    } exp_t;

    logic clk;
    logic rst;
    rpn_bcd_stack_if #(.DIGITS(4), .DEPTH(16), .PTR_W(4)) bus ();

    rpn_bcd_stack #(.DIGITS(4), .DEPTH(16), .PTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Monitor: a busy pulse ending marks a processed key; compare one clock later so the
    // registered view_bcd / view_not_top have caught up.
    initial begin
        logic busy_prev;
        int   busy_len;
        exp_t e;
        string nm;
        busy_prev = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_len++;
            if (busy_prev && !bus.busy) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk({nm, ".view_bcd"}, int'(bus.view_bcd), int'(e.bcd));
                    chk({nm, ".sp"}, int'(bus.sp), int'(e.sp));
                    chk({nm, ".view_idx"}, int'(bus.view_idx), int'(e.vidx));
                    chk({nm, ".view_not_top"}, int'(bus.view_not_top), int'(e.vnt));
                    chk({nm, ".error"}, int'(bus.error), int'(e.err));
                    if (e.blen != 4'd0) chk({nm, ".busy_len"}, busy_len, int'(e.blen));
                end
                busy_len = 0;
            end
            busy_prev = bus.busy;
        end
    end

    task automatic expect_out(input string nm, input logic [15:0] bcd, input logic [3:0] sp_e,
                              input logic [3:0] vidx, input logic err, input logic [3:0] blen);
        exp_t e;
        e.bcd  = bcd;
        e.sp   = sp_e;
        e.vidx = vidx;
        e.vnt  = (vidx != sp_e);
        e.err  = err;
        e.blen = blen;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic press(input logic [4:0] code, input string nm, input logic [15:0] bcd,
                         input logic [3:0] sp_e, input logic [3:0] vidx, input logic err,
                         input logic [3:0] blen, input int hold = 1);
        int n;
        expect_out(nm, bcd, sp_e, vidx, err, blen);
        @(posedge clk);
        #1;
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".busy_timeout"}, int'(bus.busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.key_code  = 5'd3;
        bus.key_valid = 1'b1;   // held through reset release: must not be an event
        repeat (3) @(negedge clk);
        chk("rst.view_bcd", int'(bus.view_bcd), 0);
        chk("rst.sp", int'(bus.sp), 0);
        chk("rst.view_idx", int'(bus.view_idx), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.error", int'(bus.error), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_thru_rst.busy", int'(bus.busy), 0);
        chk("held_thru_rst.view_bcd", int'(bus.view_bcd), 0);
        bus.key_valid = 1'b0;
        repeat (2) @(negedge clk);

        // 12 ENTER 34 PLUS = 46
        press(5'd1, "d1", 16'h0001, 0, 0, 0, 0);
        press(5'd2, "d2", 16'h0012, 0, 0, 0, 0);
        press(K_ENTER, "enter_a", 16'h0000, 1, 1, 0, 0);
        press(5'd3, "d3", 16'h0003, 1, 1, 0, 0);
        press(5'd4, "d4", 16'h0034, 1, 1, 0, 0);
        press(K_PLUS, "plus_46", 16'h0046, 0, 0, 0, 6);
        press(K_CLEAR, "clr_a", 16'h0000, 0, 0, 0, 0);

        // 9999 + 0001 overflows; stack kept; next key only clears error
        press(5'd9, "n9a", 16'h0009, 0, 0, 0, 0);
        press(5'd9, "n9b", 16'h0099, 0, 0, 0, 0);
        press(5'd9, "n9c", 16'h0999, 0, 0, 0, 0);
        press(5'd9, "n9d", 16'h9999, 0, 0, 0, 0);
        press(5'd5, "msd_full", 16'h9999, 0, 0, 0, 0);
        press(K_ENTER, "enter_b", 16'h0000, 1, 1, 0, 0);
        press(5'd1, "d1b", 16'h0001, 1, 1, 0, 0);
        press(K_PLUS, "plus_ovf", 16'h0001, 1, 1, 1, 6);
        press(5'd5, "err_ack", 16'h0001, 1, 1, 0, 0);
        press(K_UP, "ovf_kept0", 16'h9999, 1, 0, 0, 0);
        press(K_CLEAR, "clr_b", 16'h0000, 0, 0, 0, 0);

        // 3 - 7 borrows; 7 - 3 = 4
        press(5'd3, "m3", 16'h0003, 0, 0, 0, 0);
        press(K_ENTER, "enter_c", 16'h0000, 1, 1, 0, 0);
        press(5'd7, "m7", 16'h0007, 1, 1, 0, 0);
        press(K_MINUS, "minus_borrow", 16'h0007, 1, 1, 1, 6);
        press(K_CLEAR, "clr_err", 16'h0000, 0, 0, 0, 0);
        press(5'd7, "m7b", 16'h0007, 0, 0, 0, 0);
        press(K_ENTER, "enter_d", 16'h0000, 1, 1, 0, 0);
        press(5'd3, "m3b", 16'h0003, 1, 1, 0, 0);
        press(K_MINUS, "minus_4", 16'h0004, 0, 0, 0, 6);
        press(K_CLEAR, "clr_c", 16'h0000, 0, 0, 0, 0);

        // PLUS with sp=0 is a no-op
        press(5'd5, "d5", 16'h0005, 0, 0, 0, 0);
        press(K_PLUS, "plus_sp0", 16'h0005, 0, 0, 0, 0);
        press(K_CLEAR, "clr_d", 16'h0000, 0, 0, 0, 0);

        // Fill all 16 entries; ENTER on the full stack sets error
        for (int i = 0; i < 16; i++) begin
            press(5'd1, $sformatf("fill_d%0d", i), 16'h0001, 4'(i), 4'(i), 0, 0);
            if (i < 15) press(K_ENTER, $sformatf("fill_enter%0d", i), 16'h0000, 4'(i + 1), 4'(i + 1), 0, 0);
            else        press(K_ENTER, "full_enter", 16'h0001, 15, 15, 1, 0);
        end
        press(K_CLEAR, "clr_full", 16'h0000, 0, 0, 0, 0);
        press(K_DOWN, "down_sp0", 16'h0000, 0, 0, 0, 0);

        // Three entries, view navigation, backspace, operate-below and pop
        press(5'd1, "v1", 16'h0001, 0, 0, 0, 0);
        press(K_ENTER, "v_enter1", 16'h0000, 1, 1, 0, 0);
        press(5'd2, "v2", 16'h0002, 1, 1, 0, 0);
        press(K_ENTER, "v_enter2", 16'h0000, 2, 2, 0, 0);
        press(5'd3, "v3", 16'h0003, 2, 2, 0, 0);
        press(K_UP, "up1", 16'h0002, 2, 1, 0, 0);
        press(K_UP, "up2", 16'h0001, 2, 0, 0, 0);
        press(K_UP, "up_at0", 16'h0001, 2, 0, 0, 0);
        press(5'd4, "digit_after_up", 16'h0034, 2, 2, 0, 0);
        press(K_BACKS, "bs1", 16'h0003, 2, 2, 0, 0);
        press(K_BACKS, "bs2", 16'h0000, 2, 2, 0, 0);
        press(K_BACKS, "bs_pop", 16'h0002, 1, 1, 0, 0);
        press(K_ENTER, "v_enter3", 16'h0000, 2, 2, 0, 0);
        press(K_PLUS, "plus_below", 16'h0003, 0, 0, 0, 6);
        press(K_ENTER, "v_enter4", 16'h0000, 1, 1, 0, 0);
        press(K_PLUS, "plus_pop", 16'h0003, 0, 0, 0, 0);
        press(K_CLEAR, "clr_e", 16'h0000, 0, 0, 0, 0);

        // SWAP
        press(5'd1, "s1", 16'h0001, 0, 0, 0, 0);
        press(5'd2, "s2", 16'h0012, 0, 0, 0, 0);
        press(K_ENTER, "s_enter", 16'h0000, 1, 1, 0, 0);
        press(5'd3, "s3", 16'h0003, 1, 1, 0, 0);
        press(5'd4, "s4", 16'h0034, 1, 1, 0, 0);
`ifdef RPN_SWAP_EN
        press(K_SWAP, "swap_top", 16'h0012, 1, 1, 0, 0);
        press(K_UP, "swap_below", 16'h0034, 1, 0, 0, 0);
`else
        press(K_SWAP, "swap_nop_top", 16'h0034, 1, 1, 0, 0);
        press(K_UP, "swap_nop_below", 16'h0012, 1, 0, 0, 0);
`endif
        press(K_CLEAR, "clr_f", 16'h0000, 0, 0, 0, 0);

        // Held key gives one event
        press(5'd7, "held_key", 16'h0007, 0, 0, 0, 0, 10);
        press(5'd7, "rehit_key", 16'h0077, 0, 0, 0, 0);
        press(K_CLEAR, "clr_g", 16'h0000, 0, 0, 0, 0);

        // Reset during ARITH aborts with no partial write
        press(5'd5, "r5a", 16'h0005, 0, 0, 0, 0);
        press(K_ENTER, "r_enter", 16'h0000, 1, 1, 0, 0);
        press(5'd5, "r5b", 16'h0005, 1, 1, 0, 0);
        expect_out("arith_reset", 16'h0000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        bus.key_code  = K_PLUS;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        press(5'd1, "post_reset_digit", 16'h0001, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
